lfsr_gen: RTL

Parametrised linear-feedback shift register that generalises the team's fixed 4-bit preset LFSR to any width from 3 to 32 bits, in Fibonacci or Galois form. Adds:
- clock enable and seed load
- automatic all-zero lock-up recovery
- a step counter with a period-complete pulse

Serves as the pseudo-random source, test-pattern generator and scrambler core for later labs.

---
 rtl/lfsr_pkg.sv | 37 +++
 rtl/lfsr_next.sv | 24 ++
 rtl/lfsr_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the parametrised LFSR family.
// Tap masks use bit i = q[i] feeds back; every table entry is a primitive polynomial.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB    = 1'b0,
    LFSR_GALOIS = 1'b1
  } lfsr_mode_e;

  localparam int unsigned LFSR_MIN_WIDTH = 3;
  localparam int unsigned LFSR_MAX_WIDTH = 32;

  // Maximal-length tap masks for widths 3..16; zero means no table entry.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_default_taps(input int unsigned width);
    logic [LFSR_MAX_WIDTH-1:0] taps;
    taps = '0;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      default: taps = '0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step advance of an LFSR state in Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1001),
  parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] next
);

  if (MODE == LFSR_GALOIS) begin : g_galois
    // The bit shifted out of the top is xored back into every tapped position.
    always_comb begin
      next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
    end
  end else begin : g_fib
    always_comb begin
      next = {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with seed load, lock-up recovery and a period-complete detector.
// The reference register remembers the last seed so period_done marks a full cycle.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1001),
  parameter lfsr_mode_e       MODE  = LFSR_FIB,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] cycle_cnt
);

  if ((WIDTH < LFSR_MIN_WIDTH) || (WIDTH > LFSR_MAX_WIDTH)) begin : g_bad_width
    $error("lfsr_gen: WIDTH must lie in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             lockup_q, lockup_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_next (
    .q    (state_q),
    .next (step)
  );

  // Load wins over stepping; the all-zero state never steps, it is replaced by SEED.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    lockup_d = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      state_d = seed_in;
      ref_d   = seed_in;
      cnt_d   = '0;
    end else if (en) begin
      if (state_q == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
        done_d   = (SEED == ref_q);
        cnt_d    = '0;
      end else begin
        state_d = step;
        if (step == ref_q) begin
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
      done_q   <= done_d;
    end
  end

  assign q           = state_q;
  assign bit_out     = state_q[WIDTH-1];
  assign lockup      = lockup_q;
  assign period_done = done_q;
  assign cycle_cnt   = cnt_q;

endmodule
